a_tile_buf: RTL and testbench

//  Multi-bank A-operand tile buffer feeding the systolic array row loaders.
//  The load engine fills one bank while the array drains another, which gives
//  N-way ping-pong with per-bank ownership tracking. Generalises the single
//  A buffer: parametrised bank count, depth, width and read latency, plus lane

---
 rtl/gnpu_pkg.sv | 26 ++
 rtl/a_buf_bank.sv | 54 +++++
 rtl/a_tile_buf.sv | 187 ++++++++++++++++++
 tb/tb_a_tile_buf.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gnpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gnpu_pkg
//  Description : Types and constants shared by the GNPU operand buffers.
//                buf_state_e is the per-bank ownership state:
//                  EMPTY   - free, the load engine may write it
//                  FILLING - partially written by the load engine
//                  FULL    - committed, the array may read it
//  Revision    : 1.0 - initial release
// ============================================================================
package gnpu_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } buf_state_e;

    // Width of one systolic-array load beat.
    localparam int SARRAY_LOAD_WIDTH = 128;

    // Width of a TMMA row index; a tile holds 2**TMMA_CNT_WIDTH rows.
    localparam int TMMA_CNT_WIDTH = 4;

endpackage : gnpu_pkg
`default_nettype wire

// File: rtl/a_buf_bank.sv
`default_nettype none
// ============================================================================
//  Module      : a_buf_bank
//  Description : One DEPTH x LOAD_W storage bank with per-lane write strobes
//                and a one-cycle registered read. Contents are never reset.
//  Ports       : clk        clock
//                wr_en_i    write enable (already legality-qualified)
//                wr_addr_i  write entry index
//                wr_data_i  write data
//                wr_strb_i  lane write enables
//                rd_en_i    read enable (already legality-qualified)
//                rd_addr_i  read entry index
//                rd_data_o  read data, valid the cycle after rd_en_i
//  Revision    : 1.0 - initial release
// ============================================================================
module a_buf_bank #(
    parameter  int DEPTH  = 16,
    parameter  int LOAD_W = 128,
    parameter  int LANES  = 16,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [LOAD_W-1:0] wr_data_i,
    input  logic [LANES-1:0]  wr_strb_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [LOAD_W-1:0] rd_data_o
);

    localparam int LANE_W = LOAD_W / LANES;

    logic [LOAD_W-1:0] r_mem [DEPTH];
    logic [LOAD_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_strb_i[l]) begin
                    r_mem[wr_addr_i][l*LANE_W +: LANE_W] <= wr_data_i[l*LANE_W +: LANE_W];
                end
            end
        end
        // Hold the last read value when idle; the top masks it by valid.
        if (rd_en_i) begin
            r_rd_data <= r_mem[rd_addr_i];
        end
    end

    assign rd_data_o = r_rd_data;

endmodule : a_buf_bank
`default_nettype wire

// File: rtl/a_tile_buf.sv
`default_nettype none
// ============================================================================
//  Module      : a_tile_buf
//  Description : N-bank ping-pong A-operand tile buffer. The load engine fills
//                one bank while the systolic array drains another; each bank
//                carries an EMPTY/FILLING/FULL ownership state. Illegal
//                accesses are dropped and flagged on err_o one cycle later.
//  Ports       : clk, rst                 clock, synchronous active-high reset
//                wr_valid_i/id/addr/data  entry write request
//                wr_strb_i                lane write enables
//                wr_last_i                commit bank to FULL after this write
//                rd_valid_i/id/addr       entry read request
//                rd_last_i                release bank to EMPTY after this read
//                rd_ret_valid_o/data_o    read return, RD_LAT cycles later
//                buf_full_o/buf_empty_o   registered per-bank status
//                err_o                    pulse for any dropped access
//  Revision    : 1.0 - initial release
// ============================================================================
module a_tile_buf
    import gnpu_pkg::*;
#(
    parameter  int NUM_BUFS = 2,
    parameter  int DEPTH    = 1 << TMMA_CNT_WIDTH,
    parameter  int LOAD_W   = SARRAY_LOAD_WIDTH,
    parameter  int LANES    = 16,
    parameter  int RD_LAT   = 1,
    localparam int ID_W     = (NUM_BUFS > 2) ? $clog2(NUM_BUFS) : 1,
    localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid_i,
    input  logic [ID_W-1:0]     wr_id_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [LOAD_W-1:0]   wr_data_i,
    input  logic [LANES-1:0]    wr_strb_i,
    input  logic                wr_last_i,
    input  logic                rd_valid_i,
    input  logic [ID_W-1:0]     rd_id_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    input  logic                rd_last_i,
    output logic                rd_ret_valid_o,
    output logic [LOAD_W-1:0]   rd_ret_data_o,
    output logic [NUM_BUFS-1:0] buf_full_o,
    output logic [NUM_BUFS-1:0] buf_empty_o,
    output logic                err_o
);

    buf_state_e        r_state     [NUM_BUFS];
    buf_state_e        w_state_nxt [NUM_BUFS];
    logic [LOAD_W-1:0] w_bank_rdata [NUM_BUFS];

    logic [NUM_BUFS-1:0] r_full;
    logic [NUM_BUFS-1:0] r_empty;
    logic                r_err;
    logic                r_rd_v;
    logic [ID_W-1:0]     r_rd_id;

    logic       w_wr_id_ok, w_rd_id_ok, w_wr_addr_ok, w_rd_addr_ok;
    buf_state_e w_wr_st, w_rd_st;
    logic       w_wr_ok, w_rd_ok;
    logic [LOAD_W-1:0] w_mux_data;

    // Range checks are only needed when the field width over-covers the range.
    if ((1 << ID_W) == NUM_BUFS) begin : g_id_full
        assign w_wr_id_ok = 1'b1;
        assign w_rd_id_ok = 1'b1;
    end else begin : g_id_chk
        assign w_wr_id_ok = ({1'b0, wr_id_i} < (ID_W+1)'(NUM_BUFS));
        assign w_rd_id_ok = ({1'b0, rd_id_i} < (ID_W+1)'(NUM_BUFS));
    end

    if ((1 << ADDR_W) == DEPTH) begin : g_addr_full
        assign w_wr_addr_ok = 1'b1;
        assign w_rd_addr_ok = 1'b1;
    end else begin : g_addr_chk
        assign w_wr_addr_ok = ({1'b0, wr_addr_i} < (ADDR_W+1)'(DEPTH));
        assign w_rd_addr_ok = ({1'b0, rd_addr_i} < (ADDR_W+1)'(DEPTH));
    end

    // State of the addressed banks; an out-of-range id reads as FULL/EMPTY so
    // it can never look legal on its own (the id check also blocks it).
    always_comb begin
        w_wr_st = FULL;
        w_rd_st = EMPTY;
        for (int i = 0; i < NUM_BUFS; i++) begin
            if (wr_id_i == ID_W'(i)) w_wr_st = r_state[i];
            if (rd_id_i == ID_W'(i)) w_rd_st = r_state[i];
        end
    end

    // Requests presented during reset are ignored entirely.
    assign w_wr_ok = !rst && wr_valid_i && w_wr_id_ok && w_wr_addr_ok && (w_wr_st != FULL);
    assign w_rd_ok = !rst && rd_valid_i && w_rd_id_ok && w_rd_addr_ok && (w_rd_st == FULL);

    // Next-state logic. A legal write and a legal read never target the same
    // bank, so the two updates below cannot collide.
    always_comb begin
        for (int i = 0; i < NUM_BUFS; i++) begin
            w_state_nxt[i] = r_state[i];
            if (w_wr_ok && (wr_id_i == ID_W'(i))) begin
                w_state_nxt[i] = wr_last_i ? FULL : FILLING;
            end
            if (w_rd_ok && rd_last_i && (rd_id_i == ID_W'(i))) begin
                w_state_nxt[i] = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BUFS; i++) r_state[i] <= EMPTY;
            r_full  <= '0;
            r_empty <= '1;
            r_err   <= 1'b0;
            r_rd_v  <= 1'b0;
            r_rd_id <= '0;
        end else begin
            for (int i = 0; i < NUM_BUFS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_full[i]  <= (w_state_nxt[i] == FULL);
                r_empty[i] <= (w_state_nxt[i] == EMPTY);
            end
            r_err   <= (wr_valid_i && !w_wr_ok) || (rd_valid_i && !w_rd_ok);
            r_rd_v  <= w_rd_ok;
            r_rd_id <= rd_id_i;
        end
    end

    for (genvar g = 0; g < NUM_BUFS; g++) begin : g_bank
        a_buf_bank #(
            .DEPTH  (DEPTH),
            .LOAD_W (LOAD_W),
            .LANES  (LANES)
        ) u_bank (
            .clk       (clk),
            .wr_en_i   (w_wr_ok && (wr_id_i == ID_W'(g))),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .wr_strb_i (wr_strb_i),
            .rd_en_i   (w_rd_ok && (rd_id_i == ID_W'(g))),
            .rd_addr_i (rd_addr_i),
            .rd_data_o (w_bank_rdata[g])
        );
    end

    // Bank select; data is forced to zero whenever no return is valid.
    always_comb begin
        w_mux_data = '0;
        for (int i = 0; i < NUM_BUFS; i++) begin
            if (r_rd_v && (r_rd_id == ID_W'(i))) w_mux_data = w_bank_rdata[i];
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        assign rd_ret_valid_o = r_rd_v;
        assign rd_ret_data_o  = w_mux_data;
    end else begin : g_latn
        logic              r_pv [RD_LAT-1];
        logic [LOAD_W-1:0] r_pd [RD_LAT-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j < RD_LAT-1; j++) begin
                    r_pv[j] <= 1'b0;
                    r_pd[j] <= '0;
                end
            end else begin
                r_pv[0] <= r_rd_v;
                r_pd[0] <= w_mux_data;
                for (int j = 1; j < RD_LAT-1; j++) begin
                    r_pv[j] <= r_pv[j-1];
                    r_pd[j] <= r_pd[j-1];
                end
            end
        end

        assign rd_ret_valid_o = r_pv[RD_LAT-2];
        assign rd_ret_data_o  = r_pd[RD_LAT-2];
    end

    assign buf_full_o  = r_full;
    assign buf_empty_o = r_empty;
    assign err_o       = r_err;

endmodule : a_tile_buf
`default_nettype wire

// File: tb/tb_a_tile_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_a_tile_buf
//  Description : Self-checking bench for a_tile_buf. Two instances share the
//                same stimulus: one with RD_LAT=1, one with RD_LAT=3. A
//                transaction-level model (bank arrays, bank states, a queue of
//                expected returns) predicts every output every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_a_tile_buf;

    localparam int LW = 128;
    localparam int LANES = 16;
    localparam int LN_W = LW / LANES;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_valid_i, wr_last_i, rd_valid_i, rd_last_i;
    logic [0:0]      wr_id_i, rd_id_i;
    logic [3:0]      wr_addr_i, rd_addr_i;
    logic [LW-1:0]   wr_data_i;
    logic [LANES-1:0] wr_strb_i;

    logic            a_rv, b_rv, a_err, b_err;
    logic [LW-1:0]   a_rd, b_rd;
    logic [1:0]      a_full, a_empty, b_full, b_empty;

    always #5 clk = ~clk;

    a_tile_buf #(.NUM_BUFS(2), .DEPTH(16), .LOAD_W(LW), .LANES(LANES), .RD_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .wr_valid_i(wr_valid_i), .wr_id_i(wr_id_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i), .wr_last_i(wr_last_i),
        .rd_valid_i(rd_valid_i), .rd_id_i(rd_id_i), .rd_addr_i(rd_addr_i),
        .rd_last_i(rd_last_i),
        .rd_ret_valid_o(a_rv), .rd_ret_data_o(a_rd),
        .buf_full_o(a_full), .buf_empty_o(a_empty), .err_o(a_err)
    );

    a_tile_buf #(.NUM_BUFS(2), .DEPTH(16), .LOAD_W(LW), .LANES(LANES), .RD_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .wr_valid_i(wr_valid_i), .wr_id_i(wr_id_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i), .wr_last_i(wr_last_i),
        .rd_valid_i(rd_valid_i), .rd_id_i(rd_id_i), .rd_addr_i(rd_addr_i),
        .rd_last_i(rd_last_i),
        .rd_ret_valid_o(b_rv), .rd_ret_data_o(b_rd),
        .buf_full_o(b_full), .buf_empty_o(b_empty), .err_o(b_err)
    );

    typedef struct {
        logic             rst;
        logic             wv;
        logic [0:0]       wid;
        logic [3:0]       wa;
        logic [LW-1:0]    wd;
        logic [LANES-1:0] ws;
        logic             wl;
        logic             rv;
        logic [0:0]       rid;
        logic [3:0]       ra;
        logic             rl;
    } op_t;

    typedef struct {
        op_t        op;
        logic       e_err;
        logic [1:0] e_full;
        logic [1:0] e_empty;
        logic       e_rv;
        logic [LW-1:0] e_rd;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: bank contents, bank states (0 empty, 1 filling,
    // 2 full) and the last four predicted return slots (index 0 = newest).
    logic [LW-1:0] m_mem [2][16];
    int            m_st  [2];
    logic          m_pv  [4];
    logic [LW-1:0] m_pd  [4];
    logic          m_err;

    task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic op_t nop();
        op_t o;
        o = '{default: '0};
        return o;
    endfunction

    function automatic op_t wr(input logic id, input logic [3:0] a, input logic [LW-1:0] d,
                               input logic [LANES-1:0] s, input logic l);
        op_t o = nop();
        o.wv = 1'b1; o.wid = id; o.wa = a; o.wd = d; o.ws = s; o.wl = l;
        return o;
    endfunction

    function automatic op_t rd(input logic id, input logic [3:0] a, input logic l);
        op_t o = nop();
        o.rv = 1'b1; o.rid = id; o.ra = a; o.rl = l;
        return o;
    endfunction

    function automatic vec_t mk(input op_t o, input logic e_err, input logic [1:0] e_full,
                                input logic [1:0] e_empty, input logic e_rv, input logic [LW-1:0] e_rd);
        vec_t v;
        v.op = o; v.e_err = e_err; v.e_full = e_full; v.e_empty = e_empty;
        v.e_rv = e_rv; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic model(input op_t o);
        logic wok, rok;
        logic [LW-1:0] rdv;
        for (int j = 3; j > 0; j--) begin
            m_pv[j] = m_pv[j-1];
            m_pd[j] = m_pd[j-1];
        end
        if (o.rst) begin
            for (int j = 0; j < 4; j++) begin
                m_pv[j] = 1'b0;
                m_pd[j] = '0;
            end
            m_st[0] = 0; m_st[1] = 0;
            m_err = 1'b0;
            return;
        end
        wok = o.wv && (m_st[o.wid] != 2);
        rok = o.rv && (m_st[o.rid] == 2);
        rdv = m_mem[o.rid][o.ra];
        m_pv[0] = rok;
        m_pd[0] = rok ? rdv : '0;
        m_err = (o.wv && !wok) || (o.rv && !rok);
        if (wok) begin
            for (int l = 0; l < LANES; l++)
                if (o.ws[l]) m_mem[o.wid][o.wa][l*LN_W +: LN_W] = o.wd[l*LN_W +: LN_W];
            m_st[o.wid] = o.wl ? 2 : 1;
        end
        if (rok && o.rl) m_st[o.rid] = 0;
    endtask

    task automatic step(input op_t o);
        logic [1:0] ef, ee;
        rst = o.rst;
        wr_valid_i = o.wv; wr_id_i = o.wid; wr_addr_i = o.wa; wr_data_i = o.wd;
        wr_strb_i = o.ws; wr_last_i = o.wl;
        rd_valid_i = o.rv; rd_id_i = o.rid; rd_addr_i = o.ra; rd_last_i = o.rl;
        @(posedge clk);
        model(o);
        #1;
        for (int b = 0; b < 2; b++) begin
            ef[b] = (m_st[b] == 2);
            ee[b] = (m_st[b] == 0);
        end
        check("A_ret_valid", LW'(a_rv), LW'(m_pv[0]));
        if (m_pv[0] || o.rst) check("A_ret_data", a_rd, m_pd[0]);
        check("A_err", LW'(a_err), LW'(m_err));
        check("A_full", LW'(a_full), LW'(ef));
        check("A_empty", LW'(a_empty), LW'(ee));
        check("B_ret_valid", LW'(b_rv), LW'(m_pv[2]));
        if (m_pv[2] || o.rst) check("B_ret_data", b_rd, m_pd[2]);
        check("B_err", LW'(b_err), LW'(m_err));
        check("B_full", LW'(b_full), LW'(ef));
        check("B_empty", LW'(b_empty), LW'(ee));
    endtask

    initial begin
        vec_t tbl[$];
        op_t  o;
        logic [LW-1:0] exp_v;

        for (int b = 0; b < 2; b++) begin
            m_st[b] = 0;
            for (int a = 0; a < 16; a++) m_mem[b][a] = '0;
        end
        for (int j = 0; j < 4; j++) begin m_pv[j] = 1'b0; m_pd[j] = '0; end
        m_err = 1'b0;

        // Reset
        o = nop(); o.rst = 1'b1;
        step(o); step(o);
        check("reset_empty", LW'(a_empty), LW'(2'b11));
        check("reset_full", LW'(a_full), LW'(2'b00));
        check("reset_ret_data", a_rd, '0);

        // Fill bank0 with data = address, committing on the last entry.
        // Model memory starts at zero, so the bench initialises its view by
        // these writes.
        for (int a = 0; a < 16; a++) step(wr(1'b0, 4'(a), LW'(a), '1, a == 15));

        // Hand-derived vectors (expectations for the RD_LAT=1 instance).
        tbl.push_back(mk(rd(1'b0, 4'd3, 1'b0),            1'b0, 2'b01, 2'b10, 1'b1, LW'(3)));
        tbl.push_back(mk(rd(1'b0, 4'd5, 1'b0),            1'b0, 2'b01, 2'b10, 1'b1, LW'(5)));
        tbl.push_back(mk(wr(1'b0, 4'd1, '1, '1, 1'b0),    1'b1, 2'b01, 2'b10, 1'b0, '0));
        tbl.push_back(mk(rd(1'b1, 4'd0, 1'b0),            1'b1, 2'b01, 2'b10, 1'b0, '0));
        tbl.push_back(mk(nop(),                           1'b0, 2'b01, 2'b10, 1'b0, '0));
        tbl.push_back(mk(rd(1'b0, 4'd1, 1'b0),            1'b0, 2'b01, 2'b10, 1'b1, LW'(1)));
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].op);
            check($sformatf("vec%0d_err", i), LW'(a_err), LW'(tbl[i].e_err));
            check($sformatf("vec%0d_full", i), LW'(a_full), LW'(tbl[i].e_full));
            check($sformatf("vec%0d_empty", i), LW'(a_empty), LW'(tbl[i].e_empty));
            check($sformatf("vec%0d_rv", i), LW'(a_rv), LW'(tbl[i].e_rv));
            if (tbl[i].e_rv) check($sformatf("vec%0d_data", i), a_rd, tbl[i].e_rd);
        end

        // Ping-pong: drain bank0 while filling bank1 in the same cycles.
        for (int a = 0; a < 16; a++) begin
            o = wr(1'b1, 4'(a), {$urandom, $urandom, $urandom, $urandom}, '1, a == 15);
            o.rv = 1'b1; o.rid = 1'b0; o.ra = 4'(a); o.rl = (a == 15);
            step(o);
            check("pingpong_err", LW'(a_err), '0);
        end
        check("pingpong_full", LW'(a_full), LW'(2'b10));
        check("pingpong_empty", LW'(a_empty), LW'(2'b01));

        // Lane strobes: all ones, then zero on lane 0 only.
        step(wr(1'b0, 4'd2, '1, '1, 1'b0));
        step(wr(1'b0, 4'd2, '0, 16'h0001, 1'b1));
        step(rd(1'b0, 4'd2, 1'b1));
        exp_v = {{(LW-8){1'b1}}, 8'h00};
        check("strobe_lane0", a_rd, exp_v);

        // strb=0 still commits; entry 7 keeps its earlier value.
        step(wr(1'b0, 4'd7, '1, '0, 1'b1));
        check("strb0_full", LW'(a_full[0]), LW'(1'b1));
        step(rd(1'b0, 4'd7, 1'b1));
        check("strb0_data", a_rd, LW'(7));

        // Back-to-back reads with release, then an immediate write.
        for (int a = 0; a < 4; a++) step(rd(1'b1, 4'(a), a == 3));
        step(wr(1'b1, 4'd0, LW'(32'hABCD), '1, 1'b0));
        check("post_release_err", LW'(a_err), '0);
        check("post_release_empty", LW'(a_empty), LW'(2'b01));
        step(nop()); step(nop());

        // Reset during a read burst from a full bank0.
        for (int a = 0; a < 16; a++) step(wr(1'b0, 4'(a), LW'(a + 100), '1, a == 15));
        for (int a = 0; a < 3; a++) step(rd(1'b0, 4'(a), 1'b0));
        o = rd(1'b0, 4'd3, 1'b0); o.rst = 1'b1;
        step(o);
        check("midrst_valid", LW'(a_rv), '0);
        check("midrst_empty", LW'(a_empty), LW'(2'b11));
        step(nop()); step(nop());

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            o = nop();
            o.rst = ($urandom_range(0, 199) == 0);
            o.wv  = $urandom_range(0, 2) != 0;
            o.wid = 1'($urandom);
            o.wa  = 4'($urandom);
            o.wd  = {$urandom, $urandom, $urandom, $urandom};
            o.ws  = ($urandom_range(0, 1) == 0) ? '1 : 16'($urandom);
            o.wl  = ($urandom_range(0, 5) == 0);
            o.rv  = $urandom_range(0, 2) != 0;
            if (m_st[1] == 2 && $urandom_range(0, 3) != 0) o.rid = 1'b1;
            else if (m_st[0] == 2 && $urandom_range(0, 3) != 0) o.rid = 1'b0;
            else o.rid = 1'($urandom);
            o.ra  = 4'($urandom);
            o.rl  = ($urandom_range(0, 5) == 0);
            step(o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_a_tile_buf
`default_nettype wire
